// File: rtl/stack_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : stack_op_sequencer
// Purpose  : Sequences stack PUSH/POP operations. Owns the stack pointer,
//            drives the word-wide data-memory port for stack accesses, and
//            splits 32-bit pushes/pops into two word accesses. Publishes the
//            SP step code (000 hold, 011 +1, 100 -1) for the SP update path.
// Ports    : clk, Rst (async, active-low)
//            op_valid/op_code/op_wdata/op_ready - operation request handshake
//            mem_req/mem_we/mem_addr/mem_wdata/mem_rdata/mem_ack - memory port
//            done/fault/rd_data - completion pulse, fault pulse, pop result
//            sp/sp_ctrl - current stack pointer and SP step code
// Revision : 1.0 - initial release
// ============================================================================
module stack_op_sequencer #(
  parameter int                  ADDR_W   = 20,
  parameter int                  DATA_W   = 16,
  parameter logic [ADDR_W-1:0]   SP_RESET = 20'hFFFFF,
  parameter logic [ADDR_W-1:0]   SP_LIMIT = 20'h00800
) (
  input  logic                  clk,
  input  logic                  Rst,
  input  logic                  op_valid,
  input  logic [2:0]            op_code,
  input  logic [2*DATA_W-1:0]   op_wdata,
  output logic                  op_ready,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_ack,
  output logic                  done,
  output logic [2*DATA_W-1:0]   rd_data,
  output logic                  fault,
  output logic [ADDR_W-1:0]     sp,
  output logic [2:0]            sp_ctrl
);

  localparam logic [2:0] c_op_push16 = 3'b001;
  localparam logic [2:0] c_op_pop16  = 3'b010;
  localparam logic [2:0] c_op_push32 = 3'b011;
  localparam logic [2:0] c_op_pop32  = 3'b100;

  localparam logic [2:0] c_step_hold = 3'b000;
  localparam logic [2:0] c_step_inc1 = 3'b011;
  localparam logic [2:0] c_step_dec1 = 3'b100;

  localparam logic [ADDR_W-1:0] c_one = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_WR_HI = 3'd2,
    S_WR_LO = 3'd3,
    S_RD_LO = 3'd4,
    S_RD_HI = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t                r_state;
  logic [2:0]            r_code;
  logic [2*DATA_W-1:0]   r_wdata;
  logic [ADDR_W-1:0]     r_sp;
  logic                  r_req;
  logic                  r_we;
  logic [ADDR_W-1:0]     r_addr;
  logic [DATA_W-1:0]     r_mem_wdata;
  logic                  r_done;
  logic                  r_fault;
  logic [2*DATA_W-1:0]   r_rd_data;
  logic                  r_ready;

  logic                  w_is_32;
  logic                  w_is_push;
  logic                  w_is_pop;
  logic [ADDR_W:0]       w_sp_ext;
  logic [ADDR_W:0]       w_push_floor;
  logic [ADDR_W:0]       w_pop_top;
  logic                  w_push_ok;
  logic                  w_pop_ok;

  assign w_is_32   = (r_code == c_op_push32) || (r_code == c_op_pop32);
  assign w_is_push = (r_code == c_op_push16) || (r_code == c_op_push32);
  assign w_is_pop  = (r_code == c_op_pop16)  || (r_code == c_op_pop32);

  // Bounds are evaluated one bit wider than SP so neither side can wrap.
  // Push: sp - (n-1) >= LIMIT is rewritten as sp >= LIMIT + (n-1).
  assign w_sp_ext     = {1'b0, r_sp};
  assign w_push_floor = {1'b0, SP_LIMIT} + {{ADDR_W{1'b0}}, w_is_32};
  assign w_pop_top    = w_sp_ext + {{(ADDR_W-1){1'b0}}, w_is_32, ~w_is_32};
  assign w_push_ok    = (w_sp_ext >= w_push_floor);
  assign w_pop_ok     = (w_pop_top <= {1'b0, SP_RESET});

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      r_state     <= S_IDLE;
      r_code      <= 3'b000;
      r_wdata     <= '0;
      r_sp        <= SP_RESET;
      r_req       <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_mem_wdata <= '0;
      r_done      <= 1'b0;
      r_fault     <= 1'b0;
      r_rd_data   <= '0;
      r_ready     <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (op_valid) begin
            r_code  <= op_code;
            r_wdata <= op_wdata;
            r_ready <= 1'b0;
            if ((op_code == c_op_push16) || (op_code == c_op_pop16) ||
                (op_code == c_op_push32) || (op_code == c_op_pop32)) begin
              r_state <= S_CHECK;
            end else begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end

        S_CHECK: begin
          if (w_is_push && w_push_ok) begin
            r_req       <= 1'b1;
            r_we        <= 1'b1;
            r_addr      <= r_sp;
            r_mem_wdata <= w_is_32 ? r_wdata[2*DATA_W-1:DATA_W] : r_wdata[DATA_W-1:0];
            r_state     <= w_is_32 ? S_WR_HI : S_WR_LO;
          end else if (w_is_pop && w_pop_ok) begin
            r_req   <= 1'b1;
            r_we    <= 1'b0;
            r_addr  <= r_sp + c_one;
            r_state <= S_RD_LO;
          end else begin
            r_done  <= 1'b1;
            r_fault <= 1'b1;
            r_state <= S_DONE;
          end
        end

        S_WR_HI: begin
          if (mem_ack) begin
            // Request stays up: the low-word write follows immediately.
            r_sp        <= r_sp - c_one;
            r_addr      <= r_addr - c_one;
            r_mem_wdata <= r_wdata[DATA_W-1:0];
            r_state     <= S_WR_LO;
          end
        end

        S_WR_LO: begin
          if (mem_ack) begin
            r_sp    <= r_sp - c_one;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end

        S_RD_LO: begin
          if (mem_ack) begin
            r_sp                     <= r_sp + c_one;
            r_rd_data[DATA_W-1:0]    <= mem_rdata;
            if (w_is_32) begin
              r_addr  <= r_addr + c_one;
              r_state <= S_RD_HI;
            end else begin
              r_rd_data[2*DATA_W-1:DATA_W] <= '0;
              r_req   <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end

        S_RD_HI: begin
          if (mem_ack) begin
            r_sp                         <= r_sp + c_one;
            r_rd_data[2*DATA_W-1:DATA_W] <= mem_rdata;
            r_req                        <= 1'b0;
            r_done                       <= 1'b1;
            r_state                      <= S_DONE;
          end
        end

        S_DONE: begin
          r_done  <= 1'b0;
          r_fault <= 1'b0;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end

        default: begin
          r_req   <= 1'b0;
          r_done  <= 1'b0;
          r_fault <= 1'b0;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Step code describes the SP change taking effect at the end of this cycle.
  always_comb begin
    sp_ctrl = c_step_hold;
    if (mem_ack) begin
      if ((r_state == S_WR_HI) || (r_state == S_WR_LO)) begin
        sp_ctrl = c_step_dec1;
      end else if ((r_state == S_RD_LO) || (r_state == S_RD_HI)) begin
        sp_ctrl = c_step_inc1;
      end
    end
  end

  // Request is also gated by reset so it falls in the same instant reset asserts.
  assign mem_req   = r_req & Rst;
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_mem_wdata;
  assign op_ready  = r_ready;
  assign done      = r_done;
  assign fault     = r_fault;
  assign rd_data   = r_rd_data;
  assign sp        = r_sp;

endmodule
`default_nettype wire

// File: tb/tb_stack_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_stack_op_sequencer
// Purpose  : Self-checking bench for stack_op_sequencer. A behavioural stack
//            model predicts each operation's memory accesses and result; a
//            memory responder and a completion monitor compare the DUT against
//            those predictions through queues.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_stack_op_sequencer;

  localparam int          ADDR_W   = 20;
  localparam int          DATA_W   = 16;
  localparam logic [19:0] SP_RESET = 20'hFFFFF;
  // Limit sits close to the top so overflow is reachable in a few pushes.
  localparam logic [19:0] SP_LIMIT = 20'hFFFF8;

  localparam logic [2:0] OP_NOP    = 3'b000;
  localparam logic [2:0] OP_PUSH16 = 3'b001;
  localparam logic [2:0] OP_POP16  = 3'b010;
  localparam logic [2:0] OP_PUSH32 = 3'b011;
  localparam logic [2:0] OP_POP32  = 3'b100;

  logic                clk;
  logic                Rst;
  logic                op_valid;
  logic [2:0]          op_code;
  logic [31:0]         op_wdata;
  logic                op_ready;
  logic                mem_req;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem_rdata;
  logic                mem_ack;
  logic                done;
  logic [31:0]         rd_data;
  logic                fault;
  logic [ADDR_W-1:0]   sp;
  logic [2:0]          sp_ctrl;

  stack_op_sequencer #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .SP_RESET (SP_RESET),
    .SP_LIMIT (SP_LIMIT)
  ) dut (
    .clk       (clk),
    .Rst       (Rst),
    .op_valid  (op_valid),
    .op_code   (op_code),
    .op_wdata  (op_wdata),
    .op_ready  (op_ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .done      (done),
    .rd_data   (rd_data),
    .fault     (fault),
    .sp        (sp),
    .sp_ctrl   (sp_ctrl)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------------------------------------------------------- scoreboard
  typedef struct {
    int          addr;
    bit          we;
    logic [15:0] wdata;
  } acc_t;

  typedef struct {
    logic [2:0]  code;
    bit          fault;
    logic [31:0] rd;
    int          sp;
    bit          lat_chk;
    int          lat;
    int          cyc0;
  } res_t;

  acc_t        acc_q[$];
  res_t        res_q[$];
  logic [15:0] sim_mem[int];
  logic [15:0] mdl_mem[int];
  int          mdl_sp;
  int          ack_min = 0;
  int          ack_max = 0;

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    vectors++;
    miscompares++;
    $display("FAIL %s: event not expected by model (t=%0t)", nm, $time);
  endtask

  function automatic logic [15:0] mdl_rd(input int a);
    return mdl_mem.exists(a) ? mdl_mem[a] : 16'h0000;
  endfunction

  function automatic logic [15:0] sim_rd(input int a);
    return sim_mem.exists(a) ? sim_mem[a] : 16'h0000;
  endfunction

  // Behavioural stack: SP points at the next free word, stack grows down.
  task automatic model_accept(input logic [2:0] code, input logic [31:0] wd);
    res_t r;
    acc_t a;
    int   words;
    bit   legal;
    r.code  = code;
    r.fault = 1'b0;
    r.rd    = 32'h0;
    r.cyc0  = cyc;
    legal   = 1'b0;
    words   = (code == OP_PUSH32 || code == OP_POP32) ? 2 : 1;
    case (code)
      OP_PUSH16, OP_PUSH32: begin
        legal = (mdl_sp - (words - 1)) >= int'(SP_LIMIT);
        if (legal) begin
          if (words == 2) begin
            a.addr = mdl_sp;     a.we = 1'b1; a.wdata = wd[31:16]; acc_q.push_back(a);
            mdl_mem[mdl_sp] = wd[31:16];
            a.addr = mdl_sp - 1; a.we = 1'b1; a.wdata = wd[15:0];  acc_q.push_back(a);
            mdl_mem[mdl_sp - 1] = wd[15:0];
          end else begin
            a.addr = mdl_sp;     a.we = 1'b1; a.wdata = wd[15:0];  acc_q.push_back(a);
            mdl_mem[mdl_sp] = wd[15:0];
          end
          mdl_sp = mdl_sp - words;
        end
      end
      OP_POP16, OP_POP32: begin
        legal = (mdl_sp + words) <= int'(SP_RESET);
        if (legal) begin
          for (int k = 1; k <= words; k++) begin
            a.addr = mdl_sp + k; a.we = 1'b0; a.wdata = 16'h0; acc_q.push_back(a);
          end
          r.rd = (words == 2) ? {mdl_rd(mdl_sp + 2), mdl_rd(mdl_sp + 1)}
                              : {16'h0000, mdl_rd(mdl_sp + 1)};
          mdl_sp = mdl_sp + words;
        end
      end
      default: ;
    endcase
    r.sp = mdl_sp;
    if (code != OP_PUSH16 && code != OP_PUSH32 && code != OP_POP16 && code != OP_POP32) begin
      r.lat_chk = 1'b1; r.lat = 1;
    end else if (!legal) begin
      r.fault = 1'b1; r.lat_chk = 1'b1; r.lat = 2;
    end else begin
      r.lat_chk = (ack_max == 0); r.lat = 2 + words;
    end
    res_q.push_back(r);
  endtask

  // ----------------------------------------------------------- memory responder
  initial begin : responder
    int          wait_cnt;
    int          cur_delay;
    bit          in_acc;
    bit          sp_pend;
    int          sp_exp;
    bit          ack_we;
    logic [36:0] hold;
    acc_t        a;
    wait_cnt = 0; cur_delay = 0; in_acc = 0; sp_pend = 0; sp_exp = 0; ack_we = 0; hold = '0;
    mem_ack   = 1'b0;
    mem_rdata = 16'h0;
    forever begin
      @(posedge clk);
      #1;
      mem_ack   = 1'b0;
      mem_rdata = 16'($urandom);
      if (!Rst) begin
        in_acc = 0; wait_cnt = 0; sp_pend = 0;
      end else begin
        if (sp_pend) begin
          chk("sp_after_ack", 64'(sp), 64'(sp_exp));
          sp_pend = 0;
        end
        if (mem_req) begin
          if (!in_acc) begin
            in_acc    = 1;
            wait_cnt  = 0;
            cur_delay = ack_min + int'($urandom_range(0, ack_max - ack_min));
            hold      = {mem_we, mem_addr, mem_wdata};
          end else begin
            chk("req_fields_stable", 64'({mem_we, mem_addr, mem_wdata}), 64'(hold));
          end
          if (wait_cnt == cur_delay) begin
            if (acc_q.size() == 0) begin
              fail_now("unexpected_access");
              ack_we = mem_we;
            end else begin
              a = acc_q.pop_front();
              chk("acc_addr", 64'(mem_addr), 64'(a.addr));
              chk("acc_we", 64'(mem_we), 64'(a.we));
              if (a.we) chk("acc_wdata", 64'(mem_wdata), 64'(a.wdata));
              ack_we = a.we;
            end
            if (mem_we) sim_mem[int'(mem_addr)] = mem_wdata;
            else        mem_rdata = sim_rd(int'(mem_addr));
            mem_ack = 1'b1;
            in_acc  = 0;
            sp_pend = 1;
            sp_exp  = ack_we ? int'(sp) - 1 : int'(sp) + 1;
          end else begin
            wait_cnt++;
          end
        end else if (in_acc) begin
          fail_now("req_dropped_before_ack");
          in_acc = 0;
        end
        #1;
        if (Rst) chk("sp_ctrl", 64'(sp_ctrl),
                     64'(mem_ack ? (ack_we ? 3'b100 : 3'b011) : 3'b000));
      end
    end
  end

  // --------------------------------------------------------- completion monitor
  int done_cnt = 0;
  initial begin : monitor
    res_t e;
    forever begin
      @(posedge clk);
      #1;
      if (Rst && done) begin
        done_cnt++;
        if (res_q.size() == 0) begin
          fail_now("unexpected_done");
        end else begin
          e = res_q.pop_front();
          chk("done_fault", 64'(fault), 64'(e.fault));
          chk("done_sp", 64'(sp), 64'(e.sp));
          if (!e.fault && (e.code == OP_POP16 || e.code == OP_POP32))
            chk("pop_rd_data", 64'(rd_data), 64'(e.rd));
          if (e.lat_chk) chk("done_latency", 64'(cyc - e.cyc0), 64'(e.lat));
        end
      end else if (Rst && fault) begin
        chk("fault_without_done", 64'(done), 64'(1));
      end
    end
  end

  // ------------------------------------------------------------------- driver
  task automatic issue(input logic [2:0] code, input logic [31:0] wd);
    int t;
    t = 0;
    while (!op_ready && t < 200) begin
      @(posedge clk); #1; t++;
    end
    if (!op_ready) begin
      fail_now("op_ready_timeout");
    end else begin
      op_valid = 1'b1;
      op_code  = code;
      op_wdata = wd;
      model_accept(code, wd);
      @(posedge clk); #1;
      op_valid = 1'b0;
      op_code  = 3'($urandom);
      op_wdata = $urandom;
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((res_q.size() != 0 || !op_ready) && t < 500) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 500) fail_now("idle_timeout");
  endtask

  function automatic logic [2:0] rand_code();
    int r;
    r = int'($urandom_range(0, 11));
    if (r < 8) return 3'(r / 2 + 1);
    case (r)
      8:       return OP_NOP;
      9:       return 3'b101;
      10:      return 3'b110;
      default: return 3'b111;
    endcase
  endfunction

  task automatic clear_model();
    acc_q.delete();
    res_q.delete();
    sim_mem.delete();
    mdl_mem.delete();
    mdl_sp = int'(SP_RESET);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // --------------------------------------------------------------------- main
  initial begin : main
    int accepted;
    Rst      = 1'b0;
    op_valid = 1'b0;
    op_code  = 3'b000;
    op_wdata = 32'h0;
    clear_model();

    repeat (3) @(posedge clk);
    #1;
    chk("rst_sp", 64'(sp), 64'(SP_RESET));
    chk("rst_op_ready", 64'(op_ready), 64'(1));
    chk("rst_mem_req", 64'(mem_req), 64'(0));
    chk("rst_mem_we", 64'(mem_we), 64'(0));
    chk("rst_mem_addr", 64'(mem_addr), 64'(0));
    chk("rst_mem_wdata", 64'(mem_wdata), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_fault", 64'(fault), 64'(0));
    chk("rst_rd_data", 64'(rd_data), 64'(0));
    chk("rst_sp_ctrl", 64'(sp_ctrl), 64'(0));
    Rst = 1'b1;
    @(posedge clk); #1;

    // Reset in the middle of a PUSH32 while the high-word write awaits ack.
    ack_min = 3; ack_max = 3;
    issue(OP_PUSH32, 32'hCAFEF00D);
    @(posedge clk); #1;
    chk("req_before_reset", 64'(mem_req), 64'(1));
    #2;
    Rst = 1'b0;
    #1;
    chk("midrst_sp", 64'(sp), 64'(SP_RESET));
    chk("midrst_mem_req", 64'(mem_req), 64'(0));
    chk("midrst_op_ready", 64'(op_ready), 64'(1));
    clear_model();
    @(posedge clk); #1;
    Rst = 1'b1;
    @(posedge clk); #1;

    // Directed pushes/pops with zero-wait and with 3-cycle ack latency.
    for (int pass = 0; pass < 2; pass++) begin
      ack_min = (pass == 0) ? 0 : 3;
      ack_max = ack_min;
      issue(OP_PUSH16, 32'h00001234); wait_idle();
      issue(OP_POP16,  $urandom);     wait_idle();
      chk("pop16_example", 64'(rd_data), 64'(32'h00001234));
      issue(OP_PUSH32, 32'hDEADBEEF); wait_idle();
      chk("push32_sp", 64'(sp), 64'(20'hFFFFD));
      issue(OP_POP32,  $urandom);     wait_idle();
      chk("pop32_example", 64'(rd_data), 64'(32'hDEADBEEF));
      issue(OP_POP16,  $urandom);     wait_idle();   // underflow at empty stack
      issue(OP_NOP,    $urandom);     wait_idle();
    end

    // Fill to the limit, then probe overflow on both sizes.
    ack_min = 0; ack_max = 0;
    for (int i = 0; i < 7; i++) begin
      issue(OP_PUSH16, $urandom); wait_idle();
    end
    chk("at_limit_sp", 64'(sp), 64'(SP_LIMIT));
    issue(OP_PUSH32, $urandom); wait_idle();
    issue(OP_PUSH16, $urandom); wait_idle();
    issue(OP_PUSH16, $urandom); wait_idle();
    issue(OP_POP32,  $urandom); wait_idle();

    // Random sequential operations with random ack latency.
    ack_min = 0; ack_max = 3;
    for (int i = 0; i < 150; i++) begin
      issue(rand_code(), $urandom);
      if ($urandom_range(0, 3) == 0) wait_idle();
    end
    wait_idle();

    // op_valid held high: accepts may only happen while op_ready is high.
    for (int pass = 0; pass < 2; pass++) begin
      ack_min = 0; ack_max = (pass == 0) ? 2 : 0;
      accepted = 0;
      done_cnt = 0;
      for (int i = 0; i < 300; i++) begin
        op_valid = 1'b1;
        op_code  = rand_code();
        op_wdata = $urandom;
        if (op_ready) begin
          model_accept(op_code, op_wdata);
          accepted++;
        end
        @(posedge clk); #1;
      end
      op_valid = 1'b0;
      wait_idle();
      chk("b2b_done_count", 64'(done_cnt), 64'(accepted));
    end

    repeat (3) @(posedge clk);
    #1;
    chk("acc_queue_drained", 64'(acc_q.size()), 64'(0));
    chk("res_queue_drained", 64'(res_q.size()), 64'(0));
    chk("final_sp", 64'(sp), 64'(mdl_sp));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
